// File: rtl/spi_reg_ctrl_if.sv
// Byte-stream bus between the SPI slave front end and the command sequencer.
// The front end drives framing and received bytes; the sequencer returns the MISO load word.
interface spi_reg_ctrl_if;
  logic        frame_start;
  logic        frame_end;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [31:0] tx_word;

  modport master (
    output frame_start, frame_end, byte_valid, byte_data,
    input  tx_word
  );

  modport slave (
    input  frame_start, frame_end, byte_valid, byte_data,
    output tx_word
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Frame-aware SPI command sequencer: decodes command bytes, writes a 32-bit register bank
// and selects the MISO word. Define SPI_REG_CTRL_READBACK_EN to enable 0x2a read commands.
module spi_reg_ctrl #(
  parameter int NREG = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_reg_ctrl_if.slave        bus,
  output logic [32*NREG-1:0]   reg_flat,
  output logic                 wr_strobe,
  output logic [3:0]           wr_addr,
  output logic                 count_clr,
  output logic                 led,
  output logic                 err
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, DONE, ERR} state_t;

  localparam logic [4:0] NREG_W = 5'(NREG);

  state_t      state_reg, state_next;
  logic [3:0]  addr_reg, addr_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [31:0] hold_reg, hold_next;
  logic        led_reg, led_next;
  logic        wr_strobe_reg, wr_strobe_next;
  logic [3:0]  wr_addr_reg, wr_addr_next;
  logic        count_clr_reg, count_clr_next;
  logic        err_reg, err_next;
  logic [7:0]  err_cnt_reg, err_cnt_next;
  logic [7:0]  last_cmd_reg, last_cmd_next;
  logic [31:0] tx_word_reg, tx_word_next;
  logic        commit;
  logic        bad_cmd;
  logic [3:0]  nib;
  logic        nib_ok;

`ifdef SPI_REG_CTRL_READBACK_EN
  logic              rd_pending_reg, rd_pending_next;
  logic [31:0]       rd_data_reg, rd_data_next;
  logic [32*16-1:0]  reg_pad;

  // Zero-extended view so any nibble can index it without an out-of-range read.
  assign reg_pad = (32*16)'(reg_flat);
`endif

  assign nib    = bus.byte_data[3:0];
  assign nib_ok = ({1'b0, nib} < NREG_W);

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    cnt_next       = cnt_reg;
    hold_next      = hold_reg;
    led_next       = led_reg;
    wr_strobe_next = 1'b0;
    wr_addr_next   = wr_addr_reg;
    count_clr_next = 1'b0;
    err_next       = 1'b0;
    err_cnt_next   = err_cnt_reg;
    last_cmd_next  = last_cmd_reg;
    commit         = 1'b0;
    bad_cmd        = 1'b0;
`ifdef SPI_REG_CTRL_READBACK_EN
    rd_pending_next = rd_pending_reg;
    rd_data_next    = rd_data_reg;
`endif

    if (bus.frame_start) begin
      // A start outside IDLE means the previous end was missed: abort and reopen.
      state_next = CMD;
`ifdef SPI_REG_CTRL_READBACK_EN
      rd_pending_next = 1'b0;
`endif
    end else begin
      if (bus.byte_valid) begin
        case (state_reg)
          CMD: begin
            state_next    = DONE;
            last_cmd_next = bus.byte_data;
            casez (bus.byte_data)
              8'hCC: count_clr_next = 1'b1;
              8'hCD: led_next = 1'b1;
              8'hCE: led_next = 1'b0;
              8'h1?: begin
                if (nib_ok) begin
                  addr_next  = nib;
                  cnt_next   = 2'd0;
                  state_next = DATA;
                end else begin
                  bad_cmd = 1'b1;
                end
              end
`ifdef SPI_REG_CTRL_READBACK_EN
              8'h2?: begin
                if (nib_ok) begin
                  rd_pending_next = 1'b1;
                  rd_data_next    = reg_pad[32*nib +: 32];
                end else begin
                  bad_cmd = 1'b1;
                end
              end
`endif
              default: bad_cmd = 1'b1;
            endcase
            if (bad_cmd) begin
              state_next    = ERR;
              last_cmd_next = last_cmd_reg;
              err_next      = 1'b1;
              if (err_cnt_reg != 8'hFF) begin
                err_cnt_next = err_cnt_reg + 8'd1;
              end
            end
          end
          DATA: begin
            hold_next = {hold_reg[23:0], bus.byte_data};
            if (cnt_reg == 2'd3) begin
              commit         = 1'b1;
              wr_strobe_next = 1'b1;
              wr_addr_next   = addr_reg;
              state_next     = DONE;
            end else begin
              cnt_next = cnt_reg + 2'd1;
            end
          end
          default: ;
        endcase
      end
      if (bus.frame_end) begin
        state_next = IDLE;
      end
    end

`ifdef SPI_REG_CTRL_READBACK_EN
    tx_word_next = rd_pending_next ? rd_data_next
                                   : {8'hA5, 8'h00, err_cnt_next, last_cmd_next};
`else
    tx_word_next = {8'hA5, 8'h00, err_cnt_next, last_cmd_next};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= 4'd0;
      cnt_reg       <= 2'd0;
      hold_reg      <= 32'd0;
      led_reg       <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= 4'd0;
      count_clr_reg <= 1'b0;
      err_reg       <= 1'b0;
      err_cnt_reg   <= 8'd0;
      last_cmd_reg  <= 8'd0;
      tx_word_reg   <= 32'hA500_0000;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      cnt_reg       <= cnt_next;
      hold_reg      <= hold_next;
      led_reg       <= led_next;
      wr_strobe_reg <= wr_strobe_next;
      wr_addr_reg   <= wr_addr_next;
      count_clr_reg <= count_clr_next;
      err_reg       <= err_next;
      err_cnt_reg   <= err_cnt_next;
      last_cmd_reg  <= last_cmd_next;
      tx_word_reg   <= tx_word_next;
    end
  end

`ifdef SPI_REG_CTRL_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_reg <= 1'b0;
      rd_data_reg    <= 32'd0;
    end else begin
      rd_pending_reg <= rd_pending_next;
      rd_data_reg    <= rd_data_next;
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [31:0] reg_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          reg_q <= 32'd0;
        end else if (commit && (addr_reg == 4'(gi))) begin
          reg_q <= hold_next;
        end
      end
      assign reg_flat[32*gi +: 32] = reg_q;
    end
  endgenerate

  assign bus.tx_word = tx_word_reg;
  assign wr_strobe   = wr_strobe_reg;
  assign wr_addr     = wr_addr_reg;
  assign count_clr   = count_clr_reg;
  assign led         = led_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: table of single frames plus hand-written corner sequences.
module tb_spi_reg_ctrl;

  localparam int NREG = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [32*NREG-1:0] reg_flat;
  logic               wr_strobe;
  logic [3:0]         wr_addr;
  logic               count_clr;
  logic               led;
  logic               err;

  spi_reg_ctrl_if bus ();

  spi_reg_ctrl #(.NREG(NREG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .reg_flat  (reg_flat),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .count_clr (count_clr),
    .led       (led),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  int err_seen = 0;
  int clr_seen = 0;
  logic [3:0] last_wr_addr = 4'd0;

  // Pulse counters: a pulse stuck high for extra cycles is counted more than once.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      wr_seen      = wr_seen + 1;
      last_wr_addr = wr_addr;
    end
    if (err === 1'b1) err_seen = err_seen + 1;
    if (count_clr === 1'b1) clr_seen = clr_seen + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    tick();
  endtask

  task automatic pulse_fe();
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    tick();
  endtask

  task automatic run_frame(input logic [55:0] bytes, input int n);
    pulse_fs();
    for (int i = 0; i < n; i++) send_byte(bytes[55-8*i -: 8]);
    pulse_fe();
  endtask

  function automatic logic [31:0] rg(input int i);
    return reg_flat[32*i +: 32];
  endfunction

  typedef struct {
    logic [55:0] bytes;
    int          n;
    logic        exp_led;
    int          exp_wr;
    int          exp_err;
    int          exp_clr;
    logic [7:0]  exp_last;
    int          reg_idx;
    logic [31:0] reg_val;
  } vec_t;

  vec_t vecs [9];
  logic [7:0] exp_err_cnt = 8'd0;
  logic [7:0] exp_last = 8'd0;
  int wr0, err0, clr0;

  initial begin
    vecs[0] = '{56'h11DEADBEEF0000, 5, 1'b0, 1, 0, 0, 8'h11, 1, 32'hDEADBEEF};
    vecs[1] = '{56'h12010200000000, 3, 1'b0, 0, 0, 0, 8'h12, 2, 32'h00000000};
    vecs[2] = '{56'hCD000000000000, 1, 1'b1, 0, 0, 0, 8'hCD, 1, 32'hDEADBEEF};
    vecs[3] = '{56'hCC000000000000, 1, 1'b1, 0, 0, 1, 8'hCC, 0, 32'h00000000};
    vecs[4] = '{56'hCE000000000000, 1, 1'b0, 0, 0, 0, 8'hCE, 2, 32'h00000000};
    vecs[5] = '{56'h7F000000000000, 1, 1'b0, 0, 1, 0, 8'hCE, 1, 32'hDEADBEEF};
    vecs[6] = '{56'h1F000000000000, 1, 1'b0, 0, 1, 0, 8'hCE, 3, 32'h00000000};
    vecs[7] = '{56'h13010203045566, 7, 1'b0, 1, 0, 0, 8'h13, 3, 32'h01020304};
    vecs[8] = '{56'h7FCD0000000000, 2, 1'b0, 0, 1, 0, 8'h13, 1, 32'hDEADBEEF};

    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.byte_valid  = 1'b0;
    bus.byte_data   = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("reset_tx_word", bus.tx_word, 32'hA500_0000);
    rst_n = 1'b1;
    tick();
    pulse_fs();
    repeat (2) tick();
    chk("idle_tx_word", bus.tx_word, 32'hA500_0000);
    chk("idle_led", 32'(led), 32'd0);
    chk("idle_reg_flat_zero", 32'(reg_flat == '0), 32'd1);
    chk("idle_no_strobes", 32'(wr_seen + err_seen + clr_seen), 32'd0);
    pulse_fe();

    // Table-driven single frames
    for (int v = 0; v < 9; v++) begin
      wr0 = wr_seen; err0 = err_seen; clr0 = clr_seen;
      run_frame(vecs[v].bytes, vecs[v].n);
      exp_err_cnt = exp_err_cnt + 8'(vecs[v].exp_err);
      exp_last    = vecs[v].exp_last;
      chk("vec_led", 32'(led), 32'(vecs[v].exp_led));
      chk("vec_wr_pulses", 32'(wr_seen - wr0), 32'(vecs[v].exp_wr));
      chk("vec_err_pulses", 32'(err_seen - err0), 32'(vecs[v].exp_err));
      chk("vec_clr_pulses", 32'(clr_seen - clr0), 32'(vecs[v].exp_clr));
      chk("vec_status", bus.tx_word, {8'hA5, 8'h00, exp_err_cnt, exp_last});
      chk("vec_reg", rg(vecs[v].reg_idx), vecs[v].reg_val);
      if (vecs[v].exp_wr != 0) chk("vec_wr_addr", 32'(last_wr_addr), 32'(vecs[v].reg_idx));
      $display("TXN vec=%0d cmd=%h led=%0b tx_word=%h", v, vecs[v].bytes[55:48], led, bus.tx_word);
    end
    chk("reg0_untouched", rg(0), 32'd0);

    // Read command staging
    err0 = err_seen;
    run_frame(56'h21000000000000, 1);
`ifdef SPI_REG_CTRL_READBACK_EN
    exp_last = 8'h21;
    chk("rd_staged", bus.tx_word, 32'hDEADBEEF);
    bus.frame_start = 1'b1;
    @(negedge clk);
    chk("rd_at_frame_start", bus.tx_word, 32'hDEADBEEF);
    tick();
    bus.frame_start = 1'b0;
    @(negedge clk);
    chk("rd_reverts", bus.tx_word, {8'hA5, 8'h00, exp_err_cnt, exp_last});
    tick();
    pulse_fe();
    chk("rd_no_err", 32'(err_seen - err0), 32'd0);
`else
    exp_err_cnt = exp_err_cnt + 8'd1;
    chk("rd_unknown_err", 32'(err_seen - err0), 32'd1);
    chk("rd_unknown_status", bus.tx_word, {8'hA5, 8'h00, exp_err_cnt, exp_last});
`endif
    $display("TXN read cmd=21 tx_word=%h", bus.tx_word);

    // 4th data byte coincident with frame_end
    wr0 = wr_seen;
    pulse_fs();
    send_byte(8'h10); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    bus.byte_data = 8'h44; bus.byte_valid = 1'b1; bus.frame_end = 1'b1;
    tick();
    bus.byte_valid = 1'b0; bus.frame_end = 1'b0;
    tick();
    exp_last = 8'h10;
    chk("end_coincident_wr", 32'(wr_seen - wr0), 32'd1);
    chk("end_coincident_reg0", rg(0), 32'h11223344);
    chk("end_coincident_addr", 32'(last_wr_addr), 32'd0);
    $display("TXN write_with_end reg0=%h", rg(0));

    // Back-to-back byte_valid
    wr0 = wr_seen;
    pulse_fs();
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'h12; tick();
    bus.byte_data = 8'hA1; tick();
    bus.byte_data = 8'hB2; tick();
    bus.byte_data = 8'hC3; tick();
    bus.byte_data = 8'hD4; tick();
    bus.byte_valid = 1'b0;
    tick();
    pulse_fe();
    exp_last = 8'h12;
    chk("b2b_wr", 32'(wr_seen - wr0), 32'd1);
    chk("b2b_reg2", rg(2), 32'hA1B2C3D4);
    $display("TXN back_to_back reg2=%h", rg(2));

    // frame_start with byte_valid: byte ignored
    clr0 = clr_seen;
    bus.frame_start = 1'b1; bus.byte_valid = 1'b1; bus.byte_data = 8'hCD;
    tick();
    bus.frame_start = 1'b0; bus.byte_valid = 1'b0;
    tick();
    send_byte(8'hCC);
    pulse_fe();
    exp_last = 8'hCC;
    chk("fs_byte_ignored_led", 32'(led), 32'd0);
    chk("fs_byte_then_cmd_clr", 32'(clr_seen - clr0), 32'd1);
    chk("fs_byte_status", bus.tx_word, {8'hA5, 8'h00, exp_err_cnt, exp_last});
    $display("TXN start_with_byte led=%0b", led);

    // Missed frame_end aborts a partial write
    wr0 = wr_seen;
    pulse_fs();
    send_byte(8'h11); send_byte(8'hAA); send_byte(8'hBB);
    pulse_fs();
    send_byte(8'hCD);
    pulse_fe();
    exp_last = 8'hCD;
    chk("abort_no_wr", 32'(wr_seen - wr0), 32'd0);
    chk("abort_reg1_kept", rg(1), 32'hDEADBEEF);
    chk("abort_new_cmd_led", 32'(led), 32'd1);
    $display("TXN missed_end led=%0b reg1=%h", led, rg(1));

    // err_cnt saturation
    err0 = err_seen;
    for (int k = 0; k < 260; k++) run_frame(56'h7F000000000000, 1);
    chk("sat_err_pulses", 32'(err_seen - err0), 32'd260);
    chk("sat_err_cnt", 32'(bus.tx_word[15:8]), 32'hFF);
    chk("sat_status", bus.tx_word, {8'hA5, 8'h00, 8'hFF, exp_last});
    $display("TXN saturation tx_word=%h", bus.tx_word);

    // Asynchronous reset during DATA
    pulse_fs();
    send_byte(8'h11); send_byte(8'h01); send_byte(8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_led", 32'(led), 32'd0);
    chk("arst_reg_flat_zero", 32'(reg_flat == '0), 32'd1);
    chk("arst_tx_word", bus.tx_word, 32'hA500_0000);
    chk("arst_pulses_low", 32'({wr_strobe, err, count_clr, wr_addr}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    wr0 = wr_seen;
    send_byte(8'h03); send_byte(8'h04); send_byte(8'hCD);
    chk("post_rst_no_wr", 32'(wr_seen - wr0), 32'd0);
    chk("post_rst_ignored_led", 32'(led), 32'd0);
    chk("post_rst_reg1", rg(1), 32'd0);
    run_frame(56'hCD000000000000, 1);
    chk("post_rst_new_frame_led", 32'(led), 32'd1);
    chk("post_rst_status", bus.tx_word, 32'hA500_00CD);
    $display("TXN async_reset led=%0b tx_word=%h", led, bus.tx_word);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
